imem_responder: RTL and testbench

- Responder side of the instruction-fetch interface: a byte-addressed, big-endian instruction memory that serves fetch requests over a valid/ready handshake, with programmable wait states.
- A separate word-write load port fills the memory from the testbench or boot loader.
- Sits between the fetch stage (initiator) and the instruction store.
- Lets the pipeline be exercised against non-zero memory latency.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_array.sv | 41 ++++
 rtl/imem_responder.sv | 136 +++++++++++++
 tb/tb_imem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// word size and the fetch/load address check.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int WORD_BYTES = 4;

    // True when the whole word lies inside the array and the address is word aligned.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] offset,
                                     input logic [31:0] size);
        logic [31:0] p;
        p = addr - offset;
        return (addr >= offset) && (p <= size - 32'(WORD_BYTES)) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Byte-wide instruction store with a combinational big-endian word read port
// and a synchronous word write port; addressed by word index.
module imem_array #(
    parameter int unsigned SIZE = 8192,
    parameter int          AW   = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            i_wr_en,
    input  logic [AW-3:0]   i_wr_word,
    input  logic [0:31]     i_wr_data,
    input  logic [AW-3:0]   i_rd_word,
    output logic [0:31]     o_rd_data
);

    logic [7:0] r_mem [SIZE];

    logic [AW-1:0] w_rd_b0, w_rd_b1, w_rd_b2, w_rd_b3;
    logic [AW-1:0] w_wr_b0, w_wr_b1, w_wr_b2, w_wr_b3;

    assign w_rd_b0 = {i_rd_word, 2'b00};
    assign w_rd_b1 = {i_rd_word, 2'b01};
    assign w_rd_b2 = {i_rd_word, 2'b10};
    assign w_rd_b3 = {i_rd_word, 2'b11};
    assign w_wr_b0 = {i_wr_word, 2'b00};
    assign w_wr_b1 = {i_wr_word, 2'b01};
    assign w_wr_b2 = {i_wr_word, 2'b10};
    assign w_wr_b3 = {i_wr_word, 2'b11};

    // Lowest byte address lands in bits [0:7].
    assign o_rd_data = {r_mem[w_rd_b0], r_mem[w_rd_b1], r_mem[w_rd_b2], r_mem[w_rd_b3]};

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[w_wr_b0] <= i_wr_data[0:7];
            r_mem[w_wr_b1] <= i_wr_data[8:15];
            r_mem[w_wr_b2] <= i_wr_data[16:23];
            r_mem[w_wr_b3] <= i_wr_data[24:31];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder over valid/ready with LATENCY wait states and a word load port.
// Optional IMEM_PERF_CNT_EN adds fetch_count / err_count performance counters.
//
// state | meaning
// IDLE  | ready for a request, req_ready=1
// WAIT  | request captured, counting down wait states
// RESP  | response held until resp_ready
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned SIZE    = 8192,
    parameter logic [31:0] OFFSET  = 32'h0,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:31] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [0:31] resp_instr,
    output logic        resp_err,
    input  logic        ld_en,
    input  logic [0:31] ld_addr,
    input  logic [0:31] ld_data
`ifdef IMEM_PERF_CNT_EN
    ,
    output logic [0:31] fetch_count,
    output logic [0:15] err_count
`endif
);

    localparam int         AW       = $clog2(SIZE);
    localparam logic [3:0] LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [0:31]   r_resp_instr;
    logic          r_resp_err;

    logic [31:0]   w_fetch_addr;
    logic          w_fetch_ok;
    logic          w_ld_ok;
    logic [AW-3:0] w_rd_word;
    logic [AW-3:0] w_wr_word;
    logic [0:31]   w_rd_data;
    logic          w_accept;
    logic          w_done;
    logic          w_enter_resp;

    // With zero wait states the word is sampled straight from the request bus.
    assign w_fetch_addr = (r_state == IDLE) ? req_addr : r_addr;
    assign w_fetch_ok   = addr_ok(w_fetch_addr, OFFSET, 32'(SIZE));
    assign w_ld_ok      = addr_ok(ld_addr, OFFSET, 32'(SIZE));
    assign w_rd_word    = (AW-2)'((w_fetch_addr - OFFSET) >> 2);
    assign w_wr_word    = (AW-2)'((ld_addr - OFFSET) >> 2);

    assign w_accept     = req_valid && req_ready;
    assign w_done       = resp_valid && resp_ready;
    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

    imem_array #(.SIZE(SIZE), .AW(AW)) u_array (
        .clk       (clk),
        .i_wr_en   (ld_en && w_ld_ok),
        .i_wr_word (w_wr_word),
        .i_wr_data (ld_data),
        .i_rd_word (w_rd_word),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (r_cnt == 4'd0) w_next = RESP;
            RESP: if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == RESP);
    end

    // Array read and load write share the edge, so a colliding load is seen next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_addr       <= 32'h0;
            r_resp_instr <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                r_cnt  <= LAT_INIT;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_resp_instr <= w_fetch_ok ? w_rd_data : 32'h0;
                r_resp_err   <= !w_fetch_ok;
            end
        end
    end

    assign resp_instr = r_resp_instr;
    assign resp_err   = r_resp_err;

`ifdef IMEM_PERF_CNT_EN
    logic [0:31] r_fetch_count;
    logic [0:15] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= 32'h0;
            r_err_count   <= 16'h0;
        end else if (w_done) begin
            r_fetch_count <= r_fetch_count + 32'd1;
            if (r_resp_err && r_err_count != 16'hFFFF)
                r_err_count <= r_err_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign err_count   = r_err_count;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances cover LATENCY=2, LATENCY=0
// and OFFSET=0x1000; perf counters checked when IMEM_PERF_CNT_EN is defined.
module tb_imem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [0:31] req_addr   [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [0:31] resp_instr [3];
    logic        resp_err   [3];
    logic        ld_en      [3];
    logic [0:31] ld_addr    [3];
    logic [0:31] ld_data    [3];
`ifdef IMEM_PERF_CNT_EN
    logic [0:31] fetch_count [3];
    logic [0:15] err_count   [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    imem_responder #(.SIZE(8192), .OFFSET(32'h0), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_instr(resp_instr[0]), .resp_err(resp_err[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
`ifdef IMEM_PERF_CNT_EN
        , .fetch_count(fetch_count[0]), .err_count(err_count[0])
`endif
    );

    imem_responder #(.SIZE(8192), .OFFSET(32'h0), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_instr(resp_instr[1]), .resp_err(resp_err[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
`ifdef IMEM_PERF_CNT_EN
        , .fetch_count(fetch_count[1]), .err_count(err_count[1])
`endif
    );

    imem_responder #(.SIZE(8192), .OFFSET(32'h1000), .LATENCY(2)) u_dut_off (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_instr(resp_instr[2]), .resp_err(resp_err[2]),
        .ld_en(ld_en[2]), .ld_addr(ld_addr[2]), .ld_data(ld_data[2])
`ifdef IMEM_PERF_CNT_EN
        , .fetch_count(fetch_count[2]), .err_count(err_count[2])
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [31:0] addr, input logic [31:0] data);
        ld_en[i] = 1'b1; ld_addr[i] = addr; ld_data[i] = data;
        step();
        ld_en[i] = 1'b0;
    endtask

    // Issue one request, wait for the response (bounded), consume it with resp_ready=1.
    task automatic fetch(input int i, input logic [31:0] addr,
                         output logic [31:0] instr, output logic err,
                         output int lat, output int acc_cyc);
        req_valid[i] = 1'b1; req_addr[i] = addr;
        step();
        acc_cyc = cyc;
        req_valid[i] = 1'b0;
        lat = 1;
        while (!resp_valid[i] && lat < 20) begin
            step();
            lat++;
        end
        if (!resp_valid[i]) chk("resp_timeout", 32'(resp_valid[i]), 32'h1);
        instr = resp_instr[i];
        err   = resp_err[i];
        step();
    endtask

    logic [31:0] instr;
    logic        err;
    int          lat, acc_a, acc_b, waited;

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = 32'h0; resp_ready[i] = 1'b1;
            ld_en[i] = 1'b0; ld_addr[i] = 32'h0; ld_data[i] = 32'h0;
        end
        #2;
        chk("rst_req_ready",  32'(req_ready[0]),  32'h1);
        chk("rst_resp_valid", 32'(resp_valid[0]), 32'h0);
        chk("rst_resp_instr", resp_instr[0],      32'h0);
        chk("rst_resp_err",   32'(resp_err[0]),   32'h0);
        #10 reset = 1'b0;
        step();

        // Basic fetch, LATENCY=2
        load(0, 32'h0, 32'h20010005);
        fetch(0, 32'h0, instr, err, lat, acc_a);
        chk("l2_latency", 32'(lat), 32'd3);
        chk("l2_instr",   instr,    32'h20010005);
        chk("l2_err",     32'(err), 32'h0);

        // Address checks
        fetch(0, 32'h2, instr, err, lat, acc_a);
        chk("misalign_err",   32'(err), 32'h1);
        chk("misalign_instr", instr,    32'h0);
        fetch(0, 32'd8190, instr, err, lat, acc_a);
        chk("top_overrun_err", 32'(err), 32'h1);
        load(0, 32'd8188, 32'hA5A51234);
        fetch(0, 32'd8188, instr, err, lat, acc_a);
        chk("last_word_instr", instr,    32'hA5A51234);
        chk("last_word_err",   32'(err), 32'h0);
        fetch(2, 32'h0FFC, instr, err, lat, acc_a);
        chk("below_offset_err", 32'(err), 32'h1);
        load(2, 32'h1000, 32'h11223344);
        fetch(2, 32'h1000, instr, err, lat, acc_a);
        chk("offset_instr", instr,    32'h11223344);
        chk("offset_err",   32'(err), 32'h0);

        // Dropped loads must not alias onto valid words
        load(0, 32'h10, 32'h00000055);
        load(0, 32'h12, 32'hFFFFFFFF);
        load(0, 32'd8192, 32'hFFFFFFFF);
        fetch(0, 32'h10, instr, err, lat, acc_a);
        chk("misalign_load_drop", instr, 32'h00000055);
        fetch(0, 32'h0, instr, err, lat, acc_a);
        chk("range_load_drop", instr, 32'h20010005);

        // Back-pressure hold
        resp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        step();
        req_valid[0] = 1'b0;
        waited = 0;
        while (!resp_valid[0] && waited < 20) begin step(); waited++; end
        for (int k = 0; k < 5; k++) begin
            chk("hold_flags", {29'h0, resp_valid[0], req_ready[0], resp_err[0]}, 32'b100);
            chk("hold_instr", resp_instr[0], 32'h20010005);
            step();
        end
        resp_ready[0] = 1'b1;
        step();
        chk("release_flags", {30'h0, resp_valid[0], req_ready[0]}, 32'b01);

        // LATENCY=0 back-to-back
        load(1, 32'h0, 32'h01020304);
        load(1, 32'h4, 32'hA0B0C0D0);
        fetch(1, 32'h0, instr, err, lat, acc_a);
        chk("l0_lat_a",   32'(lat), 32'd1);
        chk("l0_instr_a", instr,    32'h01020304);
        fetch(1, 32'h4, instr, err, lat, acc_b);
        chk("l0_lat_b",    32'(lat),          32'd1);
        chk("l0_instr_b",  instr,             32'hA0B0C0D0);
        chk("l0_interval", 32'(acc_b - acc_a), 32'd2);

        // Load colliding with RESP entry: old data returned
        load(0, 32'h8, 32'h0);
        req_valid[0] = 1'b1; req_addr[0] = 32'h8;
        step();
        req_valid[0] = 1'b0;
        step();
        ld_en[0] = 1'b1; ld_addr[0] = 32'h8; ld_data[0] = 32'hDEADBEEF;
        step();
        ld_en[0] = 1'b0;
        chk("rbw_valid", 32'(resp_valid[0]), 32'h1);
        chk("rbw_instr", resp_instr[0],      32'h0);
        step();
        fetch(0, 32'h8, instr, err, lat, acc_a);
        chk("rbw_refetch", instr, 32'hDEADBEEF);

        // Load during WAIT is visible to the pending fetch
        load(0, 32'hC, 32'h00000001);
        req_valid[0] = 1'b1; req_addr[0] = 32'hC;
        step();
        req_valid[0] = 1'b0;
        ld_en[0] = 1'b1; ld_addr[0] = 32'hC; ld_data[0] = 32'hCAFEF00D;
        step();
        ld_en[0] = 1'b0;
        step();
        chk("wait_load_instr", resp_instr[0], 32'hCAFEF00D);
        step();

        // Reset during WAIT
        req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        step();
        req_valid[0] = 1'b0;
        chk("pre_rst_ready", 32'(req_ready[0]), 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("rst_wait_flags", {30'h0, resp_valid[0], req_ready[0]}, 32'b01);
        #1 reset = 1'b0;
        step(); step(); step();
        chk("rst_wait_discard", 32'(resp_valid[0]), 32'h0);

        // Reset during RESP
        resp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        step();
        req_valid[0] = 1'b0;
        step(); step();
        chk("pre_rst_valid", 32'(resp_valid[0]), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_resp_flags", {30'h0, resp_valid[0], req_ready[0]}, 32'b01);
        chk("rst_resp_instr_clr", resp_instr[0], 32'h0);
        #1 reset = 1'b0;
        resp_ready[0] = 1'b1;
        step();
        fetch(0, 32'h0, instr, err, lat, acc_a);
        chk("mem_survives_rst", instr, 32'h20010005);

`ifdef IMEM_PERF_CNT_EN
        fetch(1, 32'h0, instr, err, lat, acc_a);
        fetch(1, 32'h4, instr, err, lat, acc_a);
        fetch(1, 32'h0, instr, err, lat, acc_a);
        fetch(1, 32'h2, instr, err, lat, acc_a);
        chk("perf_fetch_count", fetch_count[1],        32'd4);
        chk("perf_err_count",   32'(err_count[1]),     32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
